// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch controller: PC mux selects, FSM states, counter width.
package fetch_ctrl_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        PCS_PC4 = 2'd0,
        PCS_BR  = 2'd1,
        PCS_JR  = 2'd2,
        PCS_J   = 2'd3
    } pcs_e;

    typedef enum logic {
        ST_BOOT  = 1'b0,
        ST_FETCH = 1'b1
    } state_e;

    // PCS_PC4 doubles as "no redirect requested"; jmp outranks jr outranks branch.
    function automatic pcs_e redir_code(input logic jmp, input logic jr, input logic br);
        pcs_e code;
        if (jmp)     code = PCS_J;
        else if (jr) code = PCS_JR;
        else if (br) code = PCS_BR;
        else         code = PCS_PC4;
        return code;
    endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with increment enable and asynchronous clear.
module sat_counter
    import fetch_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC/IF-ID enables, redirect hold across imem waits, perf counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ack,
    input  logic             load_use,
    input  logic             br_taken,
    input  logic             jr,
    input  logic             jmp,
    output logic             imem_req,
    output logic [1:0]       pcsource,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             tgt_cap,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redir_cnt
);

    // state    | meaning
    // ST_BOOT  | one idle cycle after reset, no fetch
    // ST_FETCH | fetching every cycle; PC advances on imem_ack

    state_e state_q, state_d;
    logic   pend_vld_q, pend_vld_d;
    pcs_e   pend_code_q, pend_code_d;
    pcs_e   live_code;
    logic   live_vld;
    logic   consume;
    logic   capture;
    logic   stall_inc;
    logic   redir_inc;

    assign live_code = redir_code(jmp, jr, br_taken);
    assign live_vld  = (live_code != PCS_PC4);
    assign consume   = (state_q == ST_FETCH) && imem_ack && !load_use && (pend_vld_q || live_vld);
    assign capture   = (state_q == ST_FETCH) && !imem_ack && !load_use && live_vld && !pend_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pend_vld_q  <= 1'b0;
            pend_code_q <= PCS_PC4;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_vld_d  = pend_vld_q;
        pend_code_d = pend_code_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (consume) begin
                    pend_vld_d  = 1'b0;
                    pend_code_d = PCS_PC4;
                end else if (capture) begin
                    pend_vld_d  = 1'b1;
                    pend_code_d = live_code;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // A held redirect outranks a newer live one when the fetch finally completes.
    always_comb begin
        imem_req   = 1'b0;
        pcsource   = PCS_PC4;
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        tgt_cap    = 1'b0;
        stall_inc  = 1'b0;
        redir_inc  = 1'b0;
        if (state_q == ST_FETCH) begin
            imem_req = 1'b1;
            if (load_use) begin
                stall_inc = 1'b1;
            end else if (imem_ack) begin
                pc_we   = 1'b1;
                ifid_we = 1'b1;
                if (consume) begin
                    ifid_flush = 1'b1;
                    redir_inc  = 1'b1;
                    pcsource   = pend_vld_q ? pend_code_q : live_code;
                end
            end else begin
                ifid_we    = 1'b1;
                ifid_flush = 1'b1;
                tgt_cap    = capture;
            end
        end
    end

    sat_counter u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter u_redir_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redir_inc),
        .cnt (redir_cnt)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: driver queues hand-computed expectations, monitor compares.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_ack, load_use, br_taken, jr, jmp;
    logic        imem_req, pc_we, ifid_we, ifid_flush, tgt_cap;
    logic [1:0]  pcsource;
    logic [15:0] stall_cnt, redir_cnt;

    typedef struct {
        logic        req;
        logic [1:0]  pcs;
        logic        pcwe;
        logic        ifwe;
        logic        fl;
        logic        tgt;
        logic [15:0] sc;
        logic [15:0] rc;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .imem_ack   (imem_ack),
        .load_use   (load_use),
        .br_taken   (br_taken),
        .jr         (jr),
        .jmp        (jmp),
        .imem_req   (imem_req),
        .pcsource   (pcsource),
        .pc_we      (pc_we),
        .ifid_we    (ifid_we),
        .ifid_flush (ifid_flush),
        .tgt_cap    (tgt_cap),
        .stall_cnt  (stall_cnt),
        .redir_cnt  (redir_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.tag, ".imem_req"},   {15'd0, imem_req},   {15'd0, e.req});
            chk({e.tag, ".pcsource"},   {14'd0, pcsource},   {14'd0, e.pcs});
            chk({e.tag, ".pc_we"},      {15'd0, pc_we},      {15'd0, e.pcwe});
            chk({e.tag, ".ifid_we"},    {15'd0, ifid_we},    {15'd0, e.ifwe});
            if (e.ifwe) chk({e.tag, ".ifid_flush"}, {15'd0, ifid_flush}, {15'd0, e.fl});
            chk({e.tag, ".tgt_cap"},    {15'd0, tgt_cap},    {15'd0, e.tgt});
            chk({e.tag, ".stall_cnt"},  stall_cnt,           e.sc);
            chk({e.tag, ".redir_cnt"},  redir_cnt,           e.rc);
        end
    end

    // One cycle of stimulus plus the outputs expected during that cycle (counters as seen before the edge).
    task automatic vec(input string tag,
                       input logic r, input logic ack, input logic lu,
                       input logic br, input logic jrv, input logic jm,
                       input logic req, input logic [1:0] pcs, input logic pcwe,
                       input logic ifwe, input logic fl, input logic tgt,
                       input logic [15:0] sc, input logic [15:0] rc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; imem_ack = ack; load_use = lu; br_taken = br; jr = jrv; jmp = jm;
        e.req = req; e.pcs = pcs; e.pcwe = pcwe; e.ifwe = ifwe;
        e.fl = fl; e.tgt = tgt; e.sc = sc; e.rc = rc; e.tag = tag;
        sb_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; load_use = 1'b0; br_taken = 1'b0; jr = 1'b0; jmp = 1'b0;

        //    tag      rst ack lu br jr jm | req pcs we ifwe fl tgt sc rc
        vec("rst",     1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        vec("boot",    0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            vec("seq",  0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 0, 0);

        vec("jmp_br",  0, 1, 0, 1, 0, 1,   1, 3, 1, 1, 1, 0, 0, 0);
        vec("after_j", 0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 0, 1);

        vec("w_br",    0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 1, 1, 0, 1);
        vec("w_2",     0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 1);
        vec("w_3",     0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 1);
        vec("w_cons",  0, 1, 0, 0, 0, 0,   1, 1, 1, 1, 1, 0, 0, 1);
        vec("w_after", 0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 0, 2);

        vec("fw_br",   0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 1, 1, 0, 2);
        vec("fw_jmp",  0, 0, 0, 0, 0, 1,   1, 0, 0, 1, 1, 0, 0, 2);
        vec("fw_cons", 0, 1, 0, 0, 0, 1,   1, 1, 1, 1, 1, 0, 0, 2);
        vec("fw_aft",  0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 0, 3);

        vec("lu_1",    0, 1, 1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 3);
        vec("lu_2",    0, 1, 1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 1, 3);
        vec("lu_rel",  0, 1, 0, 0, 0, 1,   1, 3, 1, 1, 1, 0, 2, 3);
        vec("lu_nack", 0, 0, 1, 1, 0, 0,   1, 0, 0, 0, 0, 0, 2, 4);
        vec("lu_aft",  0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 3, 4);

        vec("pr_cap",  0, 0, 0, 0, 1, 0,   1, 0, 0, 1, 1, 1, 3, 4);
        vec("pr_rst",  1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        vec("pr_boot", 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        vec("pr_fet",  0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 0, 0);

        for (int i = 0; i < 65540; i++)
            vec("sat",  0, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0,
                (i > 65535) ? 16'hFFFF : 16'(i), 0);
        vec("sat_end", 0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 16'hFFFF, 0);

        repeat (4) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
